i3c_timec_seq: RTL and testbench

Parametrised timing-control sequencer for I3C IBI time-control (timestamp) reporting. It measures a programmable chain of intervals on CLK_SLOW: event start to sync mark 0, then mark 0 to mark 1, and so on. Each interval is captured into a per-mark register and presented byte-wise to the IBI/GETCCC readout mux. It sits between the SCL-domain protocol engine (start and mark strobes) and the slave's read-data path. Over a fixed two-mark timer it adds a prescaler, N marks, restart mode, sticky status and a valid flag.

---
 rtl/i3c_timec_seq_if.sv | 26 ++
 rtl/i3c_timec_seq.sv | 210 +++++++++++++++++++++
 tb/tb_i3c_timec_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i3c_timec_seq_if.sv
// Bus between the SCL-domain protocol engine / readout mux and the IBI time-control sequencer.
// The master drives strobes and configuration; the slave returns capture bytes and status.
interface i3c_timec_seq_if #(
  parameter int NUM_MARKS = 2
);
  logic [1:0]           timec_ena;
  logic [7:0]           prescale;
  logic                 event_start;
  logic [NUM_MARKS-1:0] mark_in;
  logic                 clr_stat;
  logic [3:0]           info_sel;
  logic [7:0]           info_byte;
  logic                 timec_valid;
  logic                 time_overflow;
  logic                 busy;

  modport master (
    output timec_ena, prescale, event_start, mark_in, clr_stat, info_sel,
    input  info_byte, timec_valid, time_overflow, busy
  );

  modport slave (
    input  timec_ena, prescale, event_start, mark_in, clr_stat, info_sel,
    output info_byte, timec_valid, time_overflow, busy
  );
endinterface

// File: rtl/i3c_timec_seq.sv
// I3C IBI time-control sequencer: times start -> mark0 -> ... -> mark(N-1) on CLK_SLOW
// through a shared prescaler and presents each captured interval byte-wise for readout.
module i3c_timec_seq #(
  parameter int NUM_MARKS   = 2,
  parameter int T1_W        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           CLK_SLOW,
  input  logic           RSTn,
  i3c_timec_seq_if.slave bus
);

  // state   | meaning
  // ST_IDLE | waiting for a start pulse with timec_ena[0]=1
  // ST_RUN0 | timing event start -> mark 0 (T1_W-bit count)
  // ST_RUN1 | timing mark 0 -> mark 1 (8-bit count)
  // ST_RUN2 | timing mark 1 -> mark 2 (8-bit count)
  // ST_RUN3 | timing mark 2 -> mark 3 (8-bit count)
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN0 = 3'd1,
    ST_RUN1 = 3'd2,
    ST_RUN2 = 3'd3,
    ST_RUN3 = 3'd4
  } state_t;

  localparam logic [T1_W-1:0] C_MAX0  = {T1_W{1'b1}};
  localparam logic [T1_W-1:0] C_MAXK  = T1_W'(8'hFF);
  localparam logic [1:0]      C_LAST  = 2'(NUM_MARKS - 1);
  localparam int              C_T1_BY = T1_W / 8;

  logic [SYNC_STAGES-1:0] r_start_sync;
  logic [NUM_MARKS-1:0]   r_mark_sync [SYNC_STAGES];
  logic                   r_start_prev;
  logic [NUM_MARKS-1:0]   r_mark_prev;
  logic                   w_start_pls;
  logic [NUM_MARKS-1:0]   w_mark_pls;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      w_idx;
  logic            w_last;
  logic            w_mark_cur;
  logic            w_run;
  logic            w_tick;
  logic            w_sat;
  logic            w_enter;
  logic            w_capture;
  logic            w_sat_abort;
  logic            w_finish;
  logic            w_ovf_set;
  logic [T1_W-1:0] r_cnt;
  logic [T1_W-1:0] w_cnt_inc;
  logic [T1_W-1:0] w_cnt_max;
  logic [T1_W-1:0] w_cap_val;
  logic [7:0]      r_psc;
  logic [7:0]      r_ps_lat;
  logic [T1_W-1:0] r_tc [NUM_MARKS];
  logic            r_seq_ovf;
  logic            r_valid;
  logic            r_ovf;
  logic [7:0]      w_info;

  always_ff @(posedge CLK_SLOW or negedge RSTn) begin
    if (!RSTn) begin
      r_start_sync <= '0;
      r_start_prev <= 1'b0;
      r_mark_prev  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_mark_sync[i] <= '0;
    end else begin
      r_start_sync   <= {r_start_sync[SYNC_STAGES-2:0], bus.event_start};
      r_mark_sync[0] <= bus.mark_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_mark_sync[i] <= r_mark_sync[i-1];
      r_start_prev   <= r_start_sync[SYNC_STAGES-1];
      r_mark_prev    <= r_mark_sync[SYNC_STAGES-1];
    end
  end

  assign w_start_pls = r_start_sync[SYNC_STAGES-1] & ~r_start_prev;
  assign w_mark_pls  = r_mark_sync[SYNC_STAGES-1] & ~r_mark_prev;

  always_comb begin
    w_idx = 2'd0;
    case (r_state)
      ST_RUN1: w_idx = 2'd1;
      ST_RUN2: w_idx = 2'd2;
      ST_RUN3: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_mark_cur = 1'b0;
    for (int k = 0; k < NUM_MARKS; k++) begin
      if (w_idx == 2'(k)) w_mark_cur = w_mark_pls[k];
    end
  end

  assign w_last    = (w_idx == C_LAST);
  assign w_run     = (r_state != ST_IDLE) && bus.timec_ena[0];
  assign w_tick    = (r_psc == r_ps_lat);
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_cnt_max = (w_idx == 2'd0) ? C_MAX0 : C_MAXK;
  assign w_sat     = w_run && w_tick && (w_cnt_inc == w_cnt_max);
  // The capture edge's own tick is part of the interval.
  assign w_cap_val = w_tick ? w_cnt_inc : r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_capture   = 1'b0;
    w_sat_abort = 1'b0;
    w_finish    = 1'b0;
    if (!bus.timec_ena[0]) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      if (w_start_pls) begin
        w_state_nxt = ST_RUN0;
        w_enter     = 1'b1;
      end
    end else if (w_start_pls && bus.timec_ena[1]) begin
      w_state_nxt = ST_RUN0;
      w_enter     = 1'b1;
    end else if (w_mark_cur) begin
      w_capture = 1'b1;
      if (w_last) begin
        w_state_nxt = ST_IDLE;
        w_finish    = 1'b1;
      end else begin
        w_state_nxt = state_t'(r_state + 3'd1);
      end
    end else if (w_sat) begin
      w_state_nxt = ST_IDLE;
      w_sat_abort = 1'b1;
    end
  end

  assign w_ovf_set = (w_capture || w_sat_abort) && w_sat;

  always_ff @(posedge CLK_SLOW or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_psc     <= '0;
      r_ps_lat  <= '0;
      r_seq_ovf <= 1'b0;
      for (int k = 0; k < NUM_MARKS; k++) r_tc[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enter) begin
        r_cnt     <= '0;
        r_psc     <= '0;
        r_ps_lat  <= bus.prescale;
        r_seq_ovf <= 1'b0;
      end else if (w_run) begin
        // prescale is only re-sampled at a wrap so a tick period is never cut short
        if (w_tick) begin
          r_psc    <= '0;
          r_ps_lat <= bus.prescale;
        end else begin
          r_psc <= r_psc + 8'd1;
        end
        if (w_capture || w_sat_abort) begin
          r_cnt <= '0;
        end else if (w_tick) begin
          r_cnt <= w_cnt_inc;
        end
        for (int k = 0; k < NUM_MARKS; k++) begin
          if ((w_capture || w_sat_abort) && (w_idx == 2'(k))) r_tc[k] <= w_cap_val;
        end
        if (w_sat) r_seq_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_SLOW or negedge RSTn) begin
    if (!RSTn) begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_finish && !r_seq_ovf && !w_sat) begin
        r_valid <= 1'b1;
      end else if (w_enter || bus.clr_stat) begin
        r_valid <= 1'b0;
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (bus.clr_stat) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Byte map: TC[0] little-endian, then the low byte of each later interval.
  always_comb begin
    w_info = 8'h00;
    for (int b = 0; b < C_T1_BY; b++) begin
      if (bus.info_sel == 4'(b)) w_info = r_tc[0][8*b +: 8];
    end
    for (int k = 1; k < NUM_MARKS; k++) begin
      if (bus.info_sel == 4'(C_T1_BY + k - 1)) w_info = r_tc[k][7:0];
    end
  end

  assign bus.info_byte     = w_info;
  assign bus.timec_valid   = r_valid;
  assign bus.time_overflow = r_ovf;
  assign bus.busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_i3c_timec_seq.sv
// Bench for i3c_timec_seq: directed corner sequences, a table of timing vectors and
// randomized intervals checked against an arithmetic tick-count model.
module tb_i3c_timec_seq;
  localparam int NM = 2;
  localparam int TW = 16;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  i3c_timec_seq_if #(.NUM_MARKS(NM)) tif ();

  i3c_timec_seq #(
    .NUM_MARKS  (NM),
    .T1_W       (TW),
    .SYNC_STAGES(SS)
  ) dut (
    .CLK_SLOW(clk),
    .RSTn    (rst_n),
    .bus     (tif)
  );

  typedef struct {
    int          ps;
    int          d0;
    int          d1;
    logic [15:0] tc0;
    logic [7:0]  tc1;
    logic        valid;
    logic        ovf;
  } vec_t;

  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] sel, output logic [7:0] b);
    tif.info_sel = sel;
    #1;
    b = tif.info_byte;
  endtask

  task automatic rd_tc(output logic [15:0] t0, output logic [7:0] t1);
    logic [7:0] b0, b1, b2;
    rd(4'd0, b0);
    rd(4'd1, b1);
    rd(4'd2, b2);
    t0 = {b1, b0};
    t1 = b2;
  endtask

  task automatic pulse_start();
    tif.event_start = 1'b1;
    cyc(2);
    tif.event_start = 1'b0;
  endtask

  task automatic pulse_mark(input int k);
    tif.mark_in[k] = 1'b1;
    cyc(2);
    tif.mark_in[k] = 1'b0;
  endtask

  task automatic clr();
    tif.clr_stat = 1'b1;
    cyc(1);
    tif.clr_stat = 1'b0;
  endtask

  // Start edge, mark0 d0 cycles later, mark1 d1 cycles after that; waits for completion.
  task automatic run_seq(input int ps, input int d0, input int d1);
    tif.prescale = 8'(ps);
    pulse_start();
    cyc(d0 - 2);
    pulse_mark(0);
    cyc(d1 - 2);
    pulse_mark(1);
    cyc(SS + 3);
  endtask

  initial begin
    logic [15:0] g0;
    logic [7:0]  g1;
    logic [7:0]  b;
    int          ps, d0, d1, p;
    int          e0, e1;

    vt[0] = '{0, 300, 45, 16'h012C, 8'h2D, 1'b1, 1'b0};
    vt[1] = '{3, 400, 40, 16'h0064, 8'h0A, 1'b1, 1'b0};
    vt[2] = '{3, 402, 42, 16'h0064, 8'h0B, 1'b1, 1'b0};
    vt[3] = '{1,   7,  9, 16'h0003, 8'h05, 1'b1, 1'b0};
    vt[4] = '{0,   3, 255, 16'h0003, 8'hFF, 1'b0, 1'b1};
    vt[5] = '{0,   5, 254, 16'h0005, 8'hFE, 1'b1, 1'b0};
    vt[6] = '{2,  30, 12, 16'h000A, 8'h04, 1'b1, 1'b0};

    tif.timec_ena   = 2'b01;
    tif.prescale    = 8'd0;
    tif.event_start = 1'b0;
    tif.mark_in     = '0;
    tif.clr_stat    = 1'b0;
    tif.info_sel    = 4'd0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    // reset state over the whole byte window
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), b);
      check($sformatf("rst_byte%0d", i), 32'(b), 32'h0);
      cyc(1);
    end
    check("rst_busy", 32'(tif.busy), 32'h0);
    check("rst_valid", 32'(tif.timec_valid), 32'h0);
    check("rst_ovf", 32'(tif.time_overflow), 32'h0);

    // start latency, then interval 1 left to saturate at 255 ticks
    tif.prescale    = 8'd0;
    tif.event_start = 1'b1;
    cyc(SS);
    check("lat_before_entry", 32'(tif.busy), 32'h0);
    cyc(1);
    check("lat_entry", 32'(tif.busy), 32'h1);
    tif.event_start = 1'b0;
    cyc(10 - (SS + 1));
    pulse_mark(0);
    cyc(SS + 253);
    check("sat_pre_busy", 32'(tif.busy), 32'h1);
    check("sat_pre_ovf", 32'(tif.time_overflow), 32'h0);
    cyc(1);
    check("sat_busy", 32'(tif.busy), 32'h0);
    check("sat_ovf", 32'(tif.time_overflow), 32'h1);
    check("sat_valid", 32'(tif.timec_valid), 32'h0);
    rd_tc(g0, g1);
    check("sat_tc0", 32'(g0), 32'd10);
    check("sat_tc1", 32'(g1), 32'hFF);
    clr();
    check("sat_clr_ovf", 32'(tif.time_overflow), 32'h0);

    // table of timing vectors
    for (int i = 0; i < 7; i++) begin
      clr();
      run_seq(vt[i].ps, vt[i].d0, vt[i].d1);
      rd_tc(g0, g1);
      check($sformatf("vec%0d_tc0", i), 32'(g0), 32'(vt[i].tc0));
      check($sformatf("vec%0d_tc1", i), 32'(g1), 32'(vt[i].tc1));
      check($sformatf("vec%0d_valid", i), 32'(tif.timec_valid), 32'(vt[i].valid));
      check($sformatf("vec%0d_ovf", i), 32'(tif.time_overflow), 32'(vt[i].ovf));
      check($sformatf("vec%0d_busy", i), 32'(tif.busy), 32'h0);
      if (i == 0) begin
        rd(4'd3, b);
        check("vec0_byte3_unmapped", 32'(b), 32'h0);
      end
    end

    // randomized intervals: tick n (counted from RUN_0 entry) lands on edges n*(ps+1)
    for (int i = 0; i < 20; i++) begin
      ps = $urandom_range(0, 3);
      d0 = $urandom_range(3, 120);
      d1 = $urandom_range(3, 120);
      p  = ps + 1;
      e0 = d0 / p;
      e1 = (d0 + d1) / p - e0;
      clr();
      run_seq(ps, d0, d1);
      rd_tc(g0, g1);
      check($sformatf("rnd%0d_tc0 ps=%0d d0=%0d", i, ps, d0), 32'(g0), 32'(e0));
      check($sformatf("rnd%0d_tc1 ps=%0d d1=%0d", i, ps, d1), 32'(g1), 32'(e1));
      check($sformatf("rnd%0d_valid", i), 32'(tif.timec_valid), 32'h1);
    end

    // restart from RUN_1 with ena=11: TC[0] re-measured from the second start
    tif.prescale  = 8'd0;
    tif.timec_ena = 2'b11;
    pulse_start();
    cyc(18);
    pulse_mark(0);
    cyc(20);
    pulse_start();
    check("restart_busy", 32'(tif.busy), 32'h1);
    cyc(48);
    pulse_mark(0);
    cyc(8);
    pulse_mark(1);
    cyc(SS + 3);
    rd_tc(g0, g1);
    check("restart_tc0", 32'(g0), 32'd50);
    check("restart_tc1", 32'(g1), 32'd10);
    check("restart_valid", 32'(tif.timec_valid), 32'h1);

    // same stimulus with ena=01: second start and stray mark0 are ignored
    tif.timec_ena = 2'b01;
    pulse_start();
    cyc(18);
    pulse_mark(0);
    cyc(20);
    pulse_start();
    cyc(48);
    pulse_mark(0);
    cyc(8);
    pulse_mark(1);
    cyc(SS + 3);
    rd_tc(g0, g1);
    check("norestart_tc0", 32'(g0), 32'd20);
    check("norestart_tc1", 32'(g1), 32'd82);
    check("norestart_valid", 32'(tif.timec_valid), 32'h1);

    // dropping timec_ena[0] mid RUN_0 forces IDLE and keeps captures
    pulse_start();
    cyc(SS + 3);
    check("disable_pre_busy", 32'(tif.busy), 32'h1);
    tif.timec_ena = 2'b00;
    cyc(1);
    check("disable_busy", 32'(tif.busy), 32'h0);
    rd_tc(g0, g1);
    check("disable_tc0", 32'(g0), 32'd20);
    check("disable_tc1", 32'(g1), 32'd82);
    check("disable_valid", 32'(tif.timec_valid), 32'h0);

    // asynchronous reset mid-sequence clears everything without a clock edge
    tif.timec_ena = 2'b01;
    cyc(1);
    pulse_start();
    cyc(SS + 3);
    check("arst_pre_busy", 32'(tif.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(tif.busy), 32'h0);
    check("arst_valid", 32'(tif.timec_valid), 32'h0);
    check("arst_ovf", 32'(tif.time_overflow), 32'h0);
    rd_tc(g0, g1);
    check("arst_tc0", 32'(g0), 32'h0);
    check("arst_tc1", 32'(g1), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
